// File: rtl/program_sequencer_pkg.sv
// rtl/program_sequencer_pkg.sv - shared parameters, next-address select encoding, sp width helper
package program_sequencer_pkg;

   localparam int ADDR_W_DEF      = 8;
   localparam int STACK_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      NA_INC = 2'd0,
      NA_JMP = 2'd1,
      NA_RET = 2'd2
   } na_sel_e;

   // Occupancy runs 0..depth inclusive, so one extra code beyond the index range.
   function automatic int sp_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - control strobes and address outputs of the program sequencer
interface program_sequencer_if
   import program_sequencer_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
);
   localparam int SP_W = sp_width(STACK_DEPTH);

   logic              hold;
   logic              jmp;
   logic              jmp_nz;
   logic              call;
   logic              ret;
   logic [3:0]        jmp_nibble;
   logic              r_eq_0;
   logic [ADDR_W-1:0] pm_addr;
   logic [ADDR_W-1:0] pc;
   logic              stack_err;
   logic [SP_W-1:0]   sp;

   modport master (
      output hold, jmp, jmp_nz, call, ret, jmp_nibble, r_eq_0,
      input  pm_addr, pc, stack_err, sp
   );

   modport slave (
      input  hold, jmp, jmp_nz, call, ret, jmp_nibble, r_eq_0,
      output pm_addr, pc, stack_err, sp
   );
endinterface

// File: rtl/program_sequencer_call_stack.sv
// rtl/program_sequencer_call_stack.sv - ps_call_stack: return-address LIFO with occupancy count
module ps_call_stack
   import program_sequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = STACK_DEPTH_DEF,
   parameter int SP_W   = sp_width(DEPTH)
) (
   input  logic              clk,
   input  logic              sync_reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] top,
   output logic              full,
   output logic              empty,
   output logic [SP_W-1:0]   sp
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [SP_W-1:0]   sp_m1;

   assign sp_m1 = sp - 1'b1;
   assign full  = (sp == SP_W'(DEPTH));
   assign empty = (sp == '0);
   assign top   = mem[sp_m1[IDX_W-1:0]];

   // Caller never pushes and pops together; push/pop against full/empty are blocked here.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         sp <= '0;
      end else if (pop && !empty) begin
         sp <= sp_m1;
      end else if (push && !full) begin
         mem[sp[IDX_W-1:0]] <= din;
         sp <= sp + 1'b1;
      end
   end
endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program-memory address generator with jumps, call/return stack and hold
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
   input logic                clk,
   input logic                sync_reset,
   program_sequencer_if.slave bus
);
   localparam int SP_W = sp_width(STACK_DEPTH);

   na_sel_e           na_sel;
   logic              push;
   logic              pop;
   logic              err_set;
   logic              full;
   logic              empty;
   logic [ADDR_W-1:0] top;
   logic [ADDR_W-1:0] inc_addr;
   logic [ADDR_W-1:0] tgt_addr;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W-1:0] pm_addr_q;
   logic [ADDR_W-1:0] pc_q;
   logic              err_q;
   logic [SP_W-1:0]   sp;

   assign inc_addr = pm_addr_q + 1'b1;
   assign tgt_addr = {bus.jmp_nibble, {(ADDR_W-4){1'b0}}};

   // Priority: ret > call > jmp > taken jmp_nz > increment.
   always_comb begin
      na_sel  = NA_INC;
      push    = 1'b0;
      pop     = 1'b0;
      err_set = 1'b0;
      if (!bus.hold) begin
         if (bus.ret) begin
            if (empty) begin
               err_set = 1'b1;
            end else begin
               na_sel = NA_RET;
               pop    = 1'b1;
            end
         end else if (bus.call) begin
            na_sel  = NA_JMP;
            push    = !full;
            err_set = full;
         end else if (bus.jmp) begin
            na_sel = NA_JMP;
         end else if (bus.jmp_nz && !bus.r_eq_0) begin
            na_sel = NA_JMP;
         end
      end
   end

   always_comb begin
      next_addr = inc_addr;
      case (na_sel)
         NA_JMP:  next_addr = tgt_addr;
         NA_RET:  next_addr = top;
         default: next_addr = inc_addr;
      endcase
   end

   ps_call_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (STACK_DEPTH),
      .SP_W   (SP_W)
   ) u_stack (
      .clk        (clk),
      .sync_reset (sync_reset),
      .push       (push),
      .pop        (pop),
      .din        (inc_addr),
      .top        (top),
      .full       (full),
      .empty      (empty),
      .sp         (sp)
   );

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         pm_addr_q <= '0;
         pc_q      <= '0;
         err_q     <= 1'b0;
      end else if (!bus.hold) begin
         pm_addr_q <= next_addr;
         pc_q      <= pm_addr_q;
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.pm_addr   = pm_addr_q;
   assign bus.pc        = pc_q;
   assign bus.stack_err = err_q;
   assign bus.sp        = sp;
endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed self-checking bench for program_sequencer
module tb_program_sequencer;
   import program_sequencer_pkg::*;

   logic clk = 1'b0;
   logic sync_reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   program_sequencer_if #(.ADDR_W(8), .STACK_DEPTH(4)) ps_if ();

   program_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .bus        (ps_if.slave)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sync_reset = 1'b1;
      step();
      sync_reset = 1'b0;
   endtask

   task automatic clear_strobes();
      ps_if.hold   = 1'b0;
      ps_if.jmp    = 1'b0;
      ps_if.jmp_nz = 1'b0;
      ps_if.call   = 1'b0;
      ps_if.ret    = 1'b0;
      ps_if.r_eq_0 = 1'b0;
   endtask

   initial begin
      sync_reset       = 1'b1;
      ps_if.jmp_nibble = 4'h0;
      clear_strobes();
      step();
      step();
      check("rst_pm_addr", 32'(ps_if.pm_addr), 32'h00);
      check("rst_pc", 32'(ps_if.pc), 32'h00);
      check("rst_sp", 32'(ps_if.sp), 32'h0);
      check("rst_err", 32'(ps_if.stack_err), 32'h0);
      sync_reset = 1'b0;

      // Free-running increment through the 0xFF -> 0x00 wrap.
      for (int i = 1; i <= 260; i++) begin
         step();
         check("inc_pm_addr", 32'(ps_if.pm_addr), 32'(i % 256));
         check("inc_pc", 32'(ps_if.pc), 32'((i - 1) % 256));
      end
      check("inc_err", 32'(ps_if.stack_err), 32'h0);

      do_reset();
      repeat (19) step();
      check("jmp_pre", 32'(ps_if.pm_addr), 32'h13);
      ps_if.jmp = 1'b1;
      ps_if.jmp_nibble = 4'hA;
      step();
      ps_if.jmp = 1'b0;
      check("jmp_tgt", 32'(ps_if.pm_addr), 32'hA0);
      check("jmp_pc", 32'(ps_if.pc), 32'h13);
      step();
      check("jmp_next", 32'(ps_if.pm_addr), 32'hA1);

      ps_if.jmp_nz = 1'b1;
      ps_if.jmp_nibble = 4'h3;
      ps_if.r_eq_0 = 1'b0;
      step();
      ps_if.jmp_nz = 1'b0;
      check("jnz_taken", 32'(ps_if.pm_addr), 32'h30);
      repeat (16) step();
      check("jnz_pre", 32'(ps_if.pm_addr), 32'h40);
      ps_if.jmp_nz = 1'b1;
      ps_if.r_eq_0 = 1'b1;
      step();
      clear_strobes();
      check("jnz_not_taken", 32'(ps_if.pm_addr), 32'h41);

      do_reset();
      repeat (16) step();
      ps_if.call = 1'b1;
      ps_if.jmp_nibble = 4'h2;
      step();
      ps_if.call = 1'b0;
      check("call_tgt", 32'(ps_if.pm_addr), 32'h20);
      check("call_sp", 32'(ps_if.sp), 32'h1);
      repeat (5) step();
      check("ret_pre", 32'(ps_if.pm_addr), 32'h25);
      ps_if.ret = 1'b1;
      step();
      ps_if.ret = 1'b0;
      check("ret_addr", 32'(ps_if.pm_addr), 32'h11);
      check("ret_sp", 32'(ps_if.sp), 32'h0);
      check("ret_err", 32'(ps_if.stack_err), 32'h0);

      // Overflow: fifth call still jumps but cannot push.
      do_reset();
      ps_if.call = 1'b1;
      ps_if.jmp_nibble = 4'h1;
      repeat (4) step();
      check("ovf_sp4", 32'(ps_if.sp), 32'h4);
      check("ovf_err_before", 32'(ps_if.stack_err), 32'h0);
      step();
      ps_if.call = 1'b0;
      check("ovf_pm_addr", 32'(ps_if.pm_addr), 32'h10);
      check("ovf_sp", 32'(ps_if.sp), 32'h4);
      check("ovf_err", 32'(ps_if.stack_err), 32'h1);
      ps_if.ret = 1'b1;
      repeat (3) step();
      check("drain_addr_inner", 32'(ps_if.pm_addr), 32'h11);
      check("drain_sp1", 32'(ps_if.sp), 32'h1);
      step();
      check("drain_addr_outer", 32'(ps_if.pm_addr), 32'h01);
      check("drain_sp0", 32'(ps_if.sp), 32'h0);
      step();
      ps_if.ret = 1'b0;
      check("udf_pm_addr", 32'(ps_if.pm_addr), 32'h02);
      check("udf_err", 32'(ps_if.stack_err), 32'h1);
      ps_if.call = 1'b1;
      ps_if.ret = 1'b1;
      step();
      clear_strobes();
      check("callret_pm_addr", 32'(ps_if.pm_addr), 32'h03);
      check("callret_sp", 32'(ps_if.sp), 32'h0);
      step();
      check("err_sticky", 32'(ps_if.stack_err), 32'h1);

      // Return address wraps when calling from 0xFF.
      do_reset();
      check("reset_clears_err", 32'(ps_if.stack_err), 32'h0);
      repeat (255) step();
      check("wrap_pre", 32'(ps_if.pm_addr), 32'hFF);
      ps_if.call = 1'b1;
      ps_if.jmp_nibble = 4'h5;
      step();
      ps_if.call = 1'b0;
      check("wrap_call", 32'(ps_if.pm_addr), 32'h50);
      ps_if.ret = 1'b1;
      step();
      ps_if.ret = 1'b0;
      check("wrap_ret", 32'(ps_if.pm_addr), 32'h00);

      // Hold freezes everything; reset overrides hold.
      do_reset();
      ps_if.call = 1'b1;
      ps_if.jmp_nibble = 4'h1;
      repeat (3) step();
      ps_if.call = 1'b0;
      check("hold_pre_sp", 32'(ps_if.sp), 32'h3);
      ps_if.hold = 1'b1;
      ps_if.jmp = 1'b1;
      ps_if.jmp_nibble = 4'hF;
      step();
      check("hold_pm_addr", 32'(ps_if.pm_addr), 32'h10);
      check("hold_pc", 32'(ps_if.pc), 32'h10);
      check("hold_sp", 32'(ps_if.sp), 32'h3);
      sync_reset = 1'b1;
      step();
      sync_reset = 1'b0;
      clear_strobes();
      check("hrst_pm_addr", 32'(ps_if.pm_addr), 32'h00);
      check("hrst_pc", 32'(ps_if.pc), 32'h00);
      check("hrst_sp", 32'(ps_if.sp), 32'h0);
      check("hrst_err", 32'(ps_if.stack_err), 32'h0);
      step();
      check("post_rst_inc", 32'(ps_if.pm_addr), 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
